anc_out_seq: RTL and testbench
==============================

# anc_out_seq

Output sequencer for the two anti-noise speaker channels. It sits between the ANC filter outputs (yn1/yn2) and the WM8978 DAC interface. It replaces the raw key and fault muxing with a debounced enable and a click-free gain ramp, stepped once per audio frame. It also provides fault-forced muting that drives the amplifier mute pins.

## Interface
Parameters:
- DW, 16, sample width (signed)
- G, 8, gain resolution; full gain = 2^G, ramp length = 2^G frames
- DEBOUNCE_CYC, 500000, stable clk cycles required on the key (10 ms at 50 MHz)
- FAULT_HOLD, 64, consecutive fault-free frames required before re-arming

Ports:
- clk  in  1  system clock; the only clock
- rst_n  in  1  asynchronous, active-low reset
- audio_rx_down  in  1  one-cycle frame strobe from the mic deserialiser
- key_i  in  1  raw enable key (asynchronous); 1 = ANC output on
- fault1_i, fault2_i  in  1 each  raw amplifier fault inputs (asynchronous, active-high)
- yn1_i, yn2_i  in  DW each  signed anti-noise samples, valid on the audio_rx_down cycle
- yn1_o, yn2_o  out  DW each  signed scaled samples to the DAC
- mute1_o, mute2_o  out  1 each  amplifier mute; 1 = muted
- state_o  out  3  current state encoding
- busy_o  out  1  high in FADE_IN or FADE_OUT

## Operation
- Input conditioning:
  - key_i, fault1_i and fault2_i each pass through a 2-FF synchroniser.
  - key_db changes only after the synchronised key has been stable for DEBOUNCE_CYC cycles.
  - The fault inputs are not debounced. flt = fault1_s | fault2_s.
- Gain register g has range 0..2^G and width G+1.
- Output on every strobe: y = (yn * g) >>> G.
  - The product is signed, DW+G+2 bits wide.
  - The shift is arithmetic (floors toward -inf).
  - At g = 2^G, y equals yn exactly. At g = 0, y = 0.
- States:
  - MUTED = 0
  - FADE_IN = 1
  - RUN = 2
  - FADE_OUT = 3
  - FAULT = 4
- Transitions (a fault overrides everything):
  - any state, flt = 1 → FAULT. g is cleared to 0 immediately.
  - MUTED, key_db = 1 → FADE_IN.
  - FADE_IN: g increments by 1 on each strobe. When g reaches 2^G → RUN. key_db = 0 → FADE_OUT, keeping the current g.
  - RUN, key_db = 0 → FADE_OUT.
  - FADE_OUT: g decrements by 1 on each strobe. When g reaches 0 → MUTED. key_db = 1 → FADE_IN, keeping the current g.
  - FAULT → MUTED only when all of these hold:
    - flt has been 0 for FAULT_HOLD consecutive strobes;
    - key_db has been observed at 0 at least once since entering FAULT (the key must be cycled to re-arm).
- Mute outputs:
  - mute1_o and mute2_o are 1 in MUTED and FAULT, and 0 otherwise.
  - Both are driven from registers.
- Simultaneous events:
  - A gain step uses the state register value from before any transition in the same cycle.
  - Fault and strobe in the same cycle: the fault wins. Outputs load 0 and g is not stepped.
- g saturates: it never wraps above 2^G or below 0.
- Reset mid-ramp: all registers return to their reset values at once, with no fade.

## Timing
- Reset values:
  - yn1_o = yn2_o = 0
  - mute1_o = mute2_o = 1
  - state_o = 0 (MUTED)
  - busy_o = 0
  - g = 0
  - debounce and hold counters = 0
- Sample latency: yn*_o updates one cycle after the audio_rx_down cycle and holds between strobes.
- Key latency: 2 synchroniser cycles + DEBOUNCE_CYC cycles to key_db, then 1 cycle to the state change.
- Fault latency: 2 synchroniser cycles to flt. On the next edge, state = FAULT, mute = 1 and outputs = 0.
- Full ramp duration: 2^G strobes; at 48 kHz with G = 8, about 5.3 ms.

## Configuration
- ANC_OUT_RAMP_EN defined:
  - Fades behave as described above.
- ANC_OUT_RAMP_EN undefined:
  - FADE_IN and FADE_OUT are never entered.
  - MUTED with key_db = 1 → RUN, with g = 2^G immediately.
  - RUN with key_db = 0 → MUTED, with g = 0.
  - busy_o is tied to 0.

## Structure
- Shared package anc_ctrl_pkg holds:
  - the state encoding localparams;
  - default DW and G;
  - the FAULT_HOLD default.
- One sub-module, sync_debounce (parameter CYC), instanced once for the key. The fault paths use its synchroniser-only mode with CYC = 0.
- The multiply is inline: two instances of a single scaling expression.

## Test plan
Bench parameters: G = 4, DEBOUNCE_CYC = 8, FAULT_HOLD = 4. Strobe every 20 cycles, yn1_i = 1000, yn2_i = -1000.
- Reset, then no key → mute = 1, outputs 0, state_o = 0 for 50 strobes.
- key_i = 1 held → FADE_IN. Output steps to yn1_o = 62, 125, … (1000·g>>4). Reaches 1000 after 16 strobes, state = RUN; yn2_o reaches -1000 (negative steps floor, e.g. -63 at g = 1).
- Key pulse of 5 cycles (shorter than DEBOUNCE_CYC) → no state change.
- In RUN, key released, then re-pressed at g = 10 → direction reverses from g = 10. No jump in output.
- In RUN, fault1_i = 1 for 3 cycles → FAULT within 3 cycles, outputs 0, mute = 1. Stays in FAULT after 4 clean strobes while the key is held. Key released then pressed → MUTED, then FADE_IN.
- Fault and strobe in the same cycle → output 0 and g unchanged. With ANC_OUT_RAMP_EN undefined, key press → output 1000 on the first strobe.

Source files
------------

// File: rtl/anc_ctrl_pkg.sv
// Shared constants for the ANC output path: state encoding and parameter defaults.
package anc_ctrl_pkg;

   localparam logic [2:0] ST_MUTED    = 3'd0;
   localparam logic [2:0] ST_FADE_IN  = 3'd1;
   localparam logic [2:0] ST_RUN      = 3'd2;
   localparam logic [2:0] ST_FADE_OUT = 3'd3;
   localparam logic [2:0] ST_FAULT    = 3'd4;

   localparam int DW_DEF         = 16;
   localparam int G_DEF          = 8;
   localparam int FAULT_HOLD_DEF = 64;

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser with an optional stability filter; CYC = 0 gives the
// plain synchroniser.
module sync_debounce #(
   parameter int CYC = 0
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic [1:0] sync;

   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge value of its neighbours, regardless of statement order.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync <= 2'b00;
      end else begin
         sync <= {sync[0], d};
      end
   end

   generate
      if (CYC == 0) begin : g_sync_only
         assign q = sync[1];
      end else begin : g_debounce
         localparam int CW = (CYC > 1) ? $clog2(CYC) : 1;

         logic [CW-1:0] cnt;
         logic          db;

         // cnt measures how long the synchronised input has disagreed with db
         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               cnt <= '0;
               db  <= 1'b0;
            end else if (sync[1] == db) begin
               cnt <= '0;
            end else if (cnt == CW'(CYC - 1)) begin
               db  <= sync[1];
               cnt <= '0;
            end else begin
               cnt <= cnt + CW'(1);
            end
         end

         assign q = db;
      end
   endgenerate

endmodule

// File: rtl/anc_out_seq.sv
// Output sequencer for the two anti-noise channels: debounced enable, per-frame
// gain ramp and fault muting. Define ANC_OUT_RAMP_EN to enable the fades.
module anc_out_seq
   import anc_ctrl_pkg::*;
#(
   parameter int DW           = DW_DEF,
   parameter int G            = G_DEF,
   parameter int DEBOUNCE_CYC = 500000,
   parameter int FAULT_HOLD   = FAULT_HOLD_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 audio_rx_down,
   input  logic                 key_i,
   input  logic                 fault1_i,
   input  logic                 fault2_i,
   input  logic signed [DW-1:0] yn1_i,
   input  logic signed [DW-1:0] yn2_i,
   output logic signed [DW-1:0] yn1_o,
   output logic signed [DW-1:0] yn2_o,
   output logic                 mute1_o,
   output logic                 mute2_o,
   output logic [2:0]           state_o,
   output logic                 busy_o
);

   localparam int         PW        = DW + G + 2;
   localparam int         HW        = $clog2(FAULT_HOLD + 1);
   localparam logic [G:0] GAIN_FULL = {1'b1, {G{1'b0}}};

   logic                 key_db;
   logic                 fault1_s;
   logic                 fault2_s;
   logic                 flt;
   logic [2:0]           state;
   logic [2:0]           state_nxt;
   logic [G:0]           g;
   logic [G:0]           g_nxt;
   logic [HW-1:0]        hold_cnt;
   logic                 key_seen;
   logic signed [DW-1:0] y1_nxt;
   logic signed [DW-1:0] y2_nxt;

   sync_debounce #(.CYC(DEBOUNCE_CYC)) u_key (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (key_i),
      .q     (key_db)
   );

   sync_debounce #(.CYC(0)) u_flt1 (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (fault1_i),
      .q     (fault1_s)
   );

   sync_debounce #(.CYC(0)) u_flt2 (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (fault2_i),
      .q     (fault2_s)
   );

   assign flt = fault1_s | fault2_s;

   // NOTE: every signal written here gets a default first, so no path can leave
   // it unassigned and infer a latch.
   always_comb begin
      state_nxt = state;
      g_nxt     = g;
      case (state)
`ifdef ANC_OUT_RAMP_EN
         ST_MUTED: begin
            if (key_db) state_nxt = ST_FADE_IN;
         end
         ST_FADE_IN: begin
            if (audio_rx_down && (g != GAIN_FULL)) g_nxt = g + (G+1)'(1);
            if (!key_db)                           state_nxt = ST_FADE_OUT;
            else if (g_nxt == GAIN_FULL)           state_nxt = ST_RUN;
         end
         ST_RUN: begin
            if (!key_db) state_nxt = ST_FADE_OUT;
         end
         ST_FADE_OUT: begin
            if (audio_rx_down && (g != '0)) g_nxt = g - (G+1)'(1);
            if (key_db)                     state_nxt = ST_FADE_IN;
            else if (g_nxt == '0)           state_nxt = ST_MUTED;
         end
`else
         ST_MUTED: begin
            if (key_db) begin
               state_nxt = ST_RUN;
               g_nxt     = GAIN_FULL;
            end
         end
         ST_RUN: begin
            if (!key_db) begin
               state_nxt = ST_MUTED;
               g_nxt     = '0;
            end
         end
         ST_FADE_IN, ST_FADE_OUT: begin
            state_nxt = ST_MUTED;
            g_nxt     = '0;
         end
`endif
         ST_FAULT: begin
            // re-arm needs a quiet period and a deliberate key cycle
            if ((hold_cnt == HW'(FAULT_HOLD)) && (key_seen || !key_db))
               state_nxt = ST_MUTED;
         end
         default: begin
            state_nxt = ST_MUTED;
            g_nxt     = '0;
         end
      endcase

      if (flt) begin
         state_nxt = ST_FAULT;
         g_nxt     = '0;
      end
   end

   // The stepped gain is applied to the sample of the same frame.
   assign y1_nxt = DW'((PW'(yn1_i) * PW'($signed({1'b0, g_nxt}))) >>> G);
   assign y2_nxt = DW'((PW'(yn2_i) * PW'($signed({1'b0, g_nxt}))) >>> G);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= ST_MUTED;
         g        <= '0;
         yn1_o    <= '0;
         yn2_o    <= '0;
         mute1_o  <= 1'b1;
         mute2_o  <= 1'b1;
         hold_cnt <= '0;
         key_seen <= 1'b0;
      end else begin
         state   <= state_nxt;
         g       <= g_nxt;
         mute1_o <= (state_nxt == ST_MUTED) || (state_nxt == ST_FAULT);
         mute2_o <= (state_nxt == ST_MUTED) || (state_nxt == ST_FAULT);

         if (flt) begin
            yn1_o <= '0;
            yn2_o <= '0;
         end else if (audio_rx_down) begin
            yn1_o <= y1_nxt;
            yn2_o <= y2_nxt;
         end

         if (state != ST_FAULT) begin
            hold_cnt <= '0;
            key_seen <= 1'b0;
         end else begin
            if (flt)
               hold_cnt <= '0;
            else if (audio_rx_down && (hold_cnt != HW'(FAULT_HOLD)))
               hold_cnt <= hold_cnt + HW'(1);
            if (!key_db) key_seen <= 1'b1;
         end
      end
   end

   assign state_o = state;

`ifdef ANC_OUT_RAMP_EN
   assign busy_o = (state == ST_FADE_IN) || (state == ST_FADE_OUT);
`else
   assign busy_o = 1'b0;
`endif

endmodule

// File: tb/tb_anc_out_seq.sv
// Directed bench for anc_out_seq with G = 4, DEBOUNCE_CYC = 8, FAULT_HOLD = 4;
// follows whichever ANC_OUT_RAMP_EN build the RTL was compiled with.
module tb_anc_out_seq;

   logic               clk = 1'b0;
   logic               rst_n = 1'b0;
   logic               audio_rx_down = 1'b0;
   logic               key_i = 1'b0;
   logic               fault1_i = 1'b0;
   logic               fault2_i = 1'b0;
   logic signed [15:0] yn1_i = 16'sd1000;
   logic signed [15:0] yn2_i = -16'sd1000;
   logic signed [15:0] yn1_o;
   logic signed [15:0] yn2_o;
   logic               mute1_o;
   logic               mute2_o;
   logic [2:0]         state_o;
   logic               busy_o;

   int n_checks = 0;
   int n_pass   = 0;

   // Hand-computed (1000*g)>>>4 and (-1000*g)>>>4 for g = 1..16
   int pos_tab [16] = '{62, 125, 187, 250, 312, 375, 437, 500,
                        562, 625, 687, 750, 812, 875, 937, 1000};
   int neg_tab [16] = '{-63, -125, -188, -250, -313, -375, -438, -500,
                        -563, -625, -688, -750, -813, -875, -938, -1000};

`ifdef ANC_OUT_RAMP_EN
   localparam int ON_STATE = 1;
`else
   localparam int ON_STATE = 2;
`endif

   anc_out_seq #(
      .DW           (16),
      .G            (4),
      .DEBOUNCE_CYC (8),
      .FAULT_HOLD   (4)
   ) dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .audio_rx_down (audio_rx_down),
      .key_i         (key_i),
      .fault1_i      (fault1_i),
      .fault2_i      (fault2_i),
      .yn1_i         (yn1_i),
      .yn2_i         (yn2_i),
      .yn1_o         (yn1_o),
      .yn2_o         (yn2_o),
      .mute1_o       (mute1_o),
      .mute2_o       (mute2_o),
      .state_o       (state_o),
      .busy_o        (busy_o)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic signed [31:0] got,
                        input logic signed [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
   endtask

   task automatic cycles(input int n);
      repeat (n) @(negedge clk);
   endtask

   // One audio frame: a one-cycle strobe followed by 19 idle cycles.
   task automatic frame();
      @(negedge clk);
      audio_rx_down = 1'b1;
      @(negedge clk);
      audio_rx_down = 1'b0;
      cycles(18);
   endtask

   initial begin
      cycles(3);
      check("reset_state", state_o, 0);
      check("reset_mute1", mute1_o, 1);
      check("reset_mute2", mute2_o, 1);
      check("reset_yn1", yn1_o, 0);
      check("reset_yn2", yn2_o, 0);
      check("reset_busy", busy_o, 0);
      rst_n = 1'b1;

      for (int i = 0; i < 50; i++) begin
         frame();
         check("idle_state", state_o, 0);
         check("idle_yn1", yn1_o, 0);
      end
      check("idle_mute1", mute1_o, 1);

      // A 5-cycle key glitch must be filtered out
      key_i = 1'b1;
      cycles(5);
      key_i = 1'b0;
      cycles(30);
      check("glitch_state", state_o, 0);

`ifdef ANC_OUT_RAMP_EN
      key_i = 1'b1;
      cycles(15);
      check("press_state", state_o, 1);
      check("press_busy", busy_o, 1);
      check("press_mute1", mute1_o, 0);
      for (int k = 1; k <= 16; k++) begin
         frame();
         check("fadein_yn1", yn1_o, pos_tab[k-1]);
         check("fadein_yn2", yn2_o, neg_tab[k-1]);
         check("fadein_state", state_o, (k == 16) ? 2 : 1);
      end
      check("run_busy", busy_o, 0);

      key_i = 1'b0;
      cycles(15);
      check("release_state", state_o, 3);
      check("release_busy", busy_o, 1);
      for (int k = 15; k >= 10; k--) begin
         frame();
         check("fadeout_yn1", yn1_o, pos_tab[k-1]);
         check("fadeout_yn2", yn2_o, neg_tab[k-1]);
      end
      key_i = 1'b1;
      cycles(15);
      check("reverse_state", state_o, 1);
      check("reverse_hold_yn1", yn1_o, 625);
      for (int k = 11; k <= 16; k++) begin
         frame();
         check("reverse_yn1", yn1_o, pos_tab[k-1]);
         check("reverse_yn2", yn2_o, neg_tab[k-1]);
      end
      check("reverse_run", state_o, 2);
`else
      key_i = 1'b1;
      cycles(15);
      check("press_state", state_o, 2);
      check("press_mute1", mute1_o, 0);
      check("press_busy", busy_o, 0);
      frame();
      check("first_yn1", yn1_o, 1000);
      check("first_yn2", yn2_o, -1000);
      key_i = 1'b0;
      cycles(15);
      check("release_state", state_o, 0);
      check("release_mute2", mute2_o, 1);
      frame();
      check("release_yn1", yn1_o, 0);
      key_i = 1'b1;
      cycles(15);
      check("repress_state", state_o, 2);
      frame();
`endif

      // Fault while running: muted with zero output within three cycles
      fault1_i = 1'b1;
      cycles(3);
      fault1_i = 1'b0;
      check("fault_state", state_o, 4);
      check("fault_mute1", mute1_o, 1);
      check("fault_mute2", mute2_o, 1);
      check("fault_yn1", yn1_o, 0);
      check("fault_yn2", yn2_o, 0);
      check("fault_busy", busy_o, 0);
      for (int i = 0; i < 5; i++) frame();
      check("fault_hold_key_held", state_o, 4);
      key_i = 1'b0;
      cycles(15);
      check("rearm_state", state_o, 0);
      check("rearm_mute1", mute1_o, 1);
      key_i = 1'b1;
      cycles(15);
      check("rearm_on_state", state_o, ON_STATE);
      check("rearm_on_mute1", mute1_o, 0);

`ifdef ANC_OUT_RAMP_EN
      for (int i = 0; i < 3; i++) frame();
      check("pre_collide_yn1", yn1_o, 187);
      check("pre_collide_yn2", yn2_o, -188);
`else
      frame();
      check("pre_collide_yn1", yn1_o, 1000);
`endif

      // Fault reaching the FSM on the same edge as a strobe
      fault2_i = 1'b1;
      cycles(2);
      audio_rx_down = 1'b1;
      cycles(1);
      audio_rx_down = 1'b0;
      check("collide_yn1", yn1_o, 0);
      check("collide_yn2", yn2_o, 0);
      check("collide_state", state_o, 4);
      check("collide_mute2", mute2_o, 1);
      fault2_i = 1'b0;
      cycles(10);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
